// File: rtl/conc_pkg.sv
// Shared types and constants for the concolic stimulus sequencer.
// Optional feature macro used by the slice: CONC_SIG_EN (output MISR).
package conc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RST,
    PLAY,
    DONE
  } conc_seq_state_t;

  // Bit positions inside one stored vector
  localparam int unsigned VEC_START = 0;
  localparam int unsigned VEC_OBS   = 1;

  // MISR feedback taps; the MSB of the register is always the fourth tap
  localparam int unsigned MISR_TAP_A = 5;
  localparam int unsigned MISR_TAP_B = 4;
  localparam int unsigned MISR_TAP_C = 3;

endpackage

// File: rtl/conc_misr.sv
// Multiple-input signature register compacting the DUT output during replay.
// Only instantiated when CONC_SIG_EN is defined.
module conc_misr
  import conc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic fb;

  // Feedback bit from the MSB and the fixed taps
  always_comb begin
    fb = sig[W-1] ^ sig[MISR_TAP_A] ^ sig[MISR_TAP_B] ^ sig[MISR_TAP_C];
  end

  // Clear has priority over compaction; otherwise hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[W-2:0], fb} ^ din;
    end
  end

endmodule

// File: rtl/conc_stim_sequencer.sv
// Stimulus sequencer: programmable vector memory replayed onto the DUT's
// start/__obs inputs after a DUT reset pulse, with run/abort/done control.
// Define CONC_SIG_EN to add the output MISR and the signature port.
module conc_stim_sequencer
  import conc_pkg::*;
#(
  parameter  int DEPTH   = 10,
  parameter  int RST_CYC = 1,
  parameter  int OUT_W   = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [1:0]       cfg_wdata,
  input  logic [AW:0]      cfg_len,
  input  logic             run,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      pc,
  output logic             dut_reset,
  output logic             dut_start,
  output logic             dut_obs,
  input  logic [OUT_W-1:0] dut_out
`ifdef CONC_SIG_EN
  ,
  output logic [OUT_W-1:0] signature
`endif
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  conc_seq_state_t state, state_nx;
  logic [1:0]      mem [DEPTH];
  logic [AW:0]     len;
  logic [RW-1:0]   rst_cnt;
  logic [1:0]      vec;
  logic            accept, last_rst, last_vec;

  assign accept   = (state == IDLE) && run && !abort;
  assign last_rst = (rst_cnt == RW'(RST_CYC - 1));
  assign last_vec = (pc == len - (AW+1)'(1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: abort wins everywhere, run only counts in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = RST;
      RST: begin
        if (abort)         state_nx = IDLE;
        else if (last_rst) state_nx = (len != '0) ? PLAY : DONE;
      end
      PLAY: begin
        if (abort)         state_nx = IDLE;
        else if (last_vec) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Run bookkeeping: clamp length and clear counters on acceptance;
  // pc stops on the last vector and holds through abort, DONE and IDLE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      len     <= '0;
      rst_cnt <= '0;
    end else if (accept) begin
      pc      <= '0;
      rst_cnt <= '0;
      len     <= (cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len;
    end else if (!abort) begin
      if (state == RST && !last_rst)  rst_cnt <= rst_cnt + RW'(1);
      if (state == PLAY && !last_vec) pc      <= pc + (AW+1)'(1);
    end
  end

  // Vector memory: no reset, writes only in IDLE and only to real slots
  always_ff @(posedge clock) begin
    if (cfg_we && state == IDLE && {1'b0, cfg_addr} < (AW+1)'(DEPTH))
      mem[cfg_addr] <= cfg_wdata;
  end

  // Outputs decode registered state and pc only, so no input reaches them
  always_comb begin
    busy      = (state == RST) || (state == PLAY);
    done      = (state == DONE);
    dut_reset = (state == RST);
    dut_start = 1'b0;
    dut_obs   = 1'b0;
    vec       = mem[pc[AW-1:0]];
    if (state == PLAY) begin
      dut_start = vec[VEC_START];
      dut_obs   = vec[VEC_OBS];
    end
  end

`ifdef CONC_SIG_EN
  conc_misr #(.W(OUT_W)) u_misr (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .en    ((state == PLAY) && !abort),
    .din   (dut_out),
    .sig   (signature)
  );
`else
  logic unused_dut_out;
  assign unused_dut_out = ^dut_out;
`endif

endmodule

// File: tb/tb_conc_stim_sequencer.sv
// Scoreboard bench for conc_stim_sequencer: the driver pushes the expected
// per-cycle output trace of each run; a monitor pops and compares whenever
// the sequencer presents activity. Define CONC_SIG_EN to also check signature.
module tb_conc_stim_sequencer;

  localparam int DEPTH   = 10;
  localparam int RST_CYC = 1;
  localparam int OUT_W   = 8;
  localparam int AW      = 4;
  localparam int BUDGET  = RST_CYC + DEPTH + 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [1:0]       cfg_wdata;
  logic [AW:0]      cfg_len;
  logic             run;
  logic             abort;
  logic             busy;
  logic             done;
  logic [AW:0]      pc;
  logic             dut_reset;
  logic             dut_start;
  logic             dut_obs;
  logic [OUT_W-1:0] dut_out;
`ifdef CONC_SIG_EN
  logic [OUT_W-1:0] signature;
`endif

  conc_stim_sequencer #(
    .DEPTH   (DEPTH),
    .RST_CYC (RST_CYC),
    .OUT_W   (OUT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_len   (cfg_len),
    .run       (run),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .pc        (pc),
    .dut_reset (dut_reset),
    .dut_start (dut_start),
    .dut_obs   (dut_obs),
    .dut_out   (dut_out)
`ifdef CONC_SIG_EN
    ,
    .signature (signature)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rst;
    logic        start;
    logic        obs;
    logic [AW:0] pc;
  } tr_t;

  tr_t              exp_q[$];
  logic [OUT_W-1:0] sig_q[$];
  logic [1:0]       mdl_mem[DEPTH];
  int               checks   = 0;
  int               failures = 0;

  // Signature expected after n compaction steps of a constant input word
  function automatic logic [OUT_W-1:0] misr_model(input int n, input logic [OUT_W-1:0] d);
    logic [OUT_W-1:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = {s[OUT_W-2:0], s[OUT_W-1] ^ s[5] ^ s[4] ^ s[3]} ^ d;
    return s;
  endfunction

  function automatic int clamp_len(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  // Expected trace from acceptance to the done pulse
  task automatic push_trace(input int l, input logic [OUT_W-1:0] d);
    tr_t e;
    for (int i = 0; i < RST_CYC; i++) begin
      e = '{busy: 1'b1, done: 1'b0, rst: 1'b1, start: 1'b0, obs: 1'b0, pc: '0};
      exp_q.push_back(e);
    end
    for (int k = 0; k < l; k++) begin
      e = '{busy: 1'b1, done: 1'b0, rst: 1'b0, start: mdl_mem[k][0], obs: mdl_mem[k][1],
            pc: (AW+1)'(k)};
      exp_q.push_back(e);
    end
    e = '{busy: 1'b0, done: 1'b1, rst: 1'b0, start: 1'b0, obs: 1'b0,
          pc: (l == 0) ? '0 : (AW+1)'(l - 1)};
    exp_q.push_back(e);
    sig_q.push_back(misr_model(l, d));
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic write_vec(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_wdata = 2'(data);
    cycle();
    cfg_we    = 1'b0;
    if (addr < DEPTH) mdl_mem[addr] = 2'(data);
  endtask

  // Step until the expected trace drains; optional ignored run/cfg_we noise
  task automatic wait_drain(input bit inject);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      if (inject && $urandom_range(0, 2) == 0) begin
        run       = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = AW'($urandom_range(0, 15));
        cfg_wdata = 2'($urandom_range(0, 3));
      end
      cycle();
      run    = 1'b0;
      cfg_we = 1'b0;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL run_timeout pending=%0d expected=0", exp_q.size());
      exp_q.delete();
      sig_q.delete();
    end
  endtask

  task automatic do_run(input int len_in, input logic [OUT_W-1:0] d, input bit inject);
    int l;
    l       = clamp_len(len_in);
    dut_out = d;
    cfg_len = (AW+1)'(len_in);
    push_trace(l, d);
    run = 1'b1;
    cycle();
    run = 1'b0;
    wait_drain(inject);
    check_val("pc_hold_idle", int'(pc), (l == 0) ? 0 : l - 1);
  endtask

  // Monitor: every active cycle must match the head of the expected trace
  initial begin
    tr_t act;
    tr_t e;
    logic [OUT_W-1:0] s;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && (busy || done || dut_reset || dut_start || dut_obs)) begin
        act = {busy, done, dut_reset, dut_start, dut_obs, pc};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL trace_unexpected got=%b expected=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL trace busy/done/rst/start/obs/pc got=%b%b%b%b%b/%0d expected=%b%b%b%b%b/%0d",
                     act.busy, act.done, act.rst, act.start, act.obs, act.pc,
                     e.busy, e.done, e.rst, e.start, e.obs, e.pc);
          end
`ifdef CONC_SIG_EN
          if (e.done && sig_q.size() != 0) begin
            s = sig_q.pop_front();
            checks++;
            if (signature !== s) begin
              failures++;
              $display("FAIL signature got=%h expected=%h", signature, s);
            end
          end
`endif
        end
      end
    end
  end

  initial begin
    int l;
    logic [OUT_W-1:0] d;
    reset     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    cfg_len   = '0;
    run       = 1'b0;
    abort     = 1'b0;
    dut_out   = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_outputs", int'({busy, done, dut_reset, dut_start, dut_obs, pc}), 0);
`ifdef CONC_SIG_EN
    check_val("reset_signature", int'(signature), 0);
`endif
    reset = 1'b1;
    cycle();

    for (int i = 0; i < DEPTH; i++) write_vec(i, int'($urandom_range(0, 3)));

    // Basic three-vector replay
    write_vec(0, 1);
    write_vec(1, 2);
    write_vec(2, 3);
    do_run(3, 8'h5A, 1'b0);

    // Zero-length run, then over-long run clamped to DEPTH
    do_run(0, 8'h11, 1'b0);
    do_run(15, 8'hC3, 1'b0);

    // Signature reference cases
    do_run(2, 8'h01, 1'b0);
    do_run(2, 8'h00, 1'b0);

    // Abort in the second PLAY cycle, with a write attempt while busy
    d       = 8'h37;
    dut_out = d;
    cfg_len = 5'd5;
    push_trace(5, d);
    run = 1'b1;
    cycle();
    run = 1'b0;
    for (int i = 0; i < RST_CYC; i++) begin
      cfg_we    = (i == 0);
      cfg_addr  = '0;
      cfg_wdata = ~mdl_mem[0];
      cycle();
      cfg_we = 1'b0;
    end
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    exp_q.delete();
    sig_q.delete();
    check_val("abort_outputs", int'({busy, done, dut_reset, dut_start, dut_obs}), 0);
    check_val("abort_pc", int'(pc), 1);
`ifdef CONC_SIG_EN
    check_val("abort_signature", int'(signature), int'(misr_model(1, d)));
`endif
    repeat (4) cycle();
    check_val("abort_pc_later", int'(pc), 1);
    do_run(5, 8'h9E, 1'b0);

    // Asynchronous reset in the middle of PLAY, then replay the same vectors
    dut_out = 8'hA5;
    cfg_len = 5'd6;
    push_trace(6, 8'hA5);
    run = 1'b1;
    cycle();
    run = 1'b0;
    repeat (RST_CYC + 2) cycle();
    #1;
    reset = 1'b0;
    exp_q.delete();
    sig_q.delete();
    #1;
    check_val("midrun_reset_outputs", int'({busy, done, dut_reset, dut_start, dut_obs, pc}), 0);
`ifdef CONC_SIG_EN
    check_val("midrun_reset_signature", int'(signature), 0);
`endif
    cycle();
    reset = 1'b1;
    cycle();
    do_run(6, 8'hA5, 1'b0);

    // Randomised runs with idle writes (some out of range) and busy noise
    for (int r = 0; r < 25; r++) begin
      l = int'($urandom_range(0, 3));
      for (int w = 0; w < l; w++)
        write_vec(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      do_run(int'($urandom_range(0, 31)), OUT_W'($urandom), 1'b1);
    end

    repeat (3) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conc_stim_sequencer.md
# conc_stim_sequencer

Synthesizable stimulus scheduler for the concolic harness: holds a small programmable vector memory and replays it, one vector per cycle, onto the DUT's `start` and `__obs` inputs after a DUT reset pulse. It replaces the free-running program counter and fixed `$readmemb` load with a run/abort/done-controlled sequencer. Vectors are written over a config port, so one elaboration can run many generated tests back to back.

## Interface
- `DEPTH`, 10: number of vector slots.
- `RST_CYC`, 1: DUT reset pulse length in cycles, ≥1.
- `OUT_W`, 8: width of the sampled DUT output (`punti_retta`).
- `AW`, derived `$clog2(DEPTH)`: address width. Not for override.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: write strobe for the vector memory.
- `cfg_addr` in AW: write address.
- `cfg_wdata` in 2: vector; bit1 = obs, bit0 = start.
- `cfg_len` in AW+1: number of vectors to play.
- `run` in 1: start request.
- `abort` in 1: cancel the current run.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `pc` out AW+1: index of the vector currently driven.
- `dut_reset` out 1: active-high reset to the DUT.
- `dut_start` out 1: driven DUT `start`.
- `dut_obs` out 1: driven DUT `__obs`.
- `dut_out` in OUT_W: DUT output to compact.
- `signature` out OUT_W: MISR result. Present only with the macro defined.

## Operation
- FSM states: IDLE, RST, PLAY, DONE.
- IDLE:
  - `run`=1 → RST.
  - Latch `len = min(cfg_len, DEPTH)`.
  - Clear `pc`, the reset counter and `signature`.
- RST:
  - `dut_reset`=1 for RST_CYC cycles.
  - Then PLAY if `len`>0, else DONE.
- PLAY:
  - Drive `{dut_obs,dut_start} = mem[pc]`.
  - `pc` increments each cycle.
  - After the cycle with `pc==len-1` → DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in RST and PLAY only.
- `dut_start`/`dut_obs` are 0 outside PLAY.
- `pc` holds its last value in DONE and IDLE.
- Config writes:
  - Accepted only in IDLE.
  - Writes with `cfg_addr`≥DEPTH are dropped.
  - `cfg_we` while busy is ignored; memory is unchanged.
- `abort`:
  - Any non-IDLE state → IDLE next cycle. No `done` pulse.
  - Outputs return to reset values except `pc`/`signature`, which hold.
  - `abort` has priority over `run` in the same cycle.
- `run` in RST/PLAY/DONE is ignored; no queuing.
- Memory contents are not reset. Reads of unwritten slots return X in simulation.

## Timing
- Reset (asynchronous, `reset`=0):
  - State IDLE.
  - `busy`=`done`=`dut_reset`=`dut_start`=`dut_obs`=0.
  - `pc`=0, `signature`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- `run` sampled at edge t → `dut_reset`=1 from t+1 through t+RST_CYC.
- Vector k is driven during cycle t+RST_CYC+1+k.
- `done` is high in cycle t+RST_CYC+len+1.
- Total latency from `run` to `done` = RST_CYC+len+1 cycles.
- A new `run` is accepted in the cycle after `done` at the earliest.
- Reset asserted mid-run: immediate return to IDLE; memory contents are retained.

## Configuration
- `CONC_SIG_EN` defined:
  - 8-bit-style MISR over `dut_out` at every PLAY edge.
  - Update: `sig <= {sig[OUT_W-2:0], sig[OUT_W-1]^sig[5]^sig[4]^sig[3]} ^ dut_out`.
  - Cleared on `run` acceptance; held otherwise.
  - `signature` port is present.
- `CONC_SIG_EN` undefined: no MISR logic and no `signature` port; all other behaviour is identical.

## Structure
- Package `conc_pkg`:
  - FSM state enum `conc_seq_state_t`.
  - Vector bit positions `VEC_START`=0, `VEC_OBS`=1.
  - MISR tap constants.
- One sub-module, `conc_misr`: parameterised MISR. Instantiated only under `CONC_SIG_EN`.
- Vector memory is a plain register array inside the top module.

## Test plan
- Reset, then write mem[0..2] = 01,10,11, `cfg_len`=3, pulse `run` → `dut_reset`=1 for 1 cycle, then start/obs = 1/0, 0/1, 1/1 on consecutive cycles; `done` 5 cycles after `run`; `busy` high for 4 cycles.
- `cfg_len`=0, `run` → `dut_reset` pulse, then `done` next cycle; `dut_start`/`dut_obs` stay 0.
- `cfg_len`=15 with DEPTH=10 → exactly 10 PLAY cycles; `pc` ends at 9.
- `abort` in 2nd PLAY cycle of a len=5 run → IDLE next cycle, no `done`, `pc`=1 held; `cfg_we` during the run leaves the memory unchanged.
- `CONC_SIG_EN`, len=2, `dut_out`=8'h01 held → `signature`=8'h03 at `done`; with `dut_out`=0 → 8'h00.
- `reset` pulled low mid-PLAY → all outputs 0 immediately; a rerun replays the same stored vectors.
